// File: rtl/kernel_ddr3_mem_dmaster_st_arb_if.sv
// ---------------------------------------------------------------------------
// kernel_ddr3_mem_dmaster_st_arb_if
// Purpose : bundles the two requester byte streams and the arbitrated output
//           stream of kernel_ddr3_mem_dmaster_st_arb into one interface.
// Signals : in0_* / in1_*  requester streams (valid, ready, data, sop, eop)
//           out_*          arbitrated stream (valid, ready, data, sop, eop,
//                          channel = index of the requester that sent the beat)
// Modports: slave  - the arbiter side (consumes in*, produces out*)
//           master - the environment side (produces in*, consumes out*)
//
// Handshake: a beat moves across a stream on a rising clock edge where
// valid and ready are both high. The sender holds valid and its payload
// stable until that edge. ready may be high while valid is low; that
// transfers nothing.
// ---------------------------------------------------------------------------
interface kernel_ddr3_mem_dmaster_st_arb_if #(
  parameter int DATA_W = 8
);
  logic              in0_valid;
  logic              in0_ready;
  logic [DATA_W-1:0] in0_data;
  logic              in0_sop;
  logic              in0_eop;

  logic              in1_valid;
  logic              in1_ready;
  logic [DATA_W-1:0] in1_data;
  logic              in1_sop;
  logic              in1_eop;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic              out_channel;

  modport slave (
    input  in0_valid, in0_data, in0_sop, in0_eop,
    output in0_ready,
    input  in1_valid, in1_data, in1_sop, in1_eop,
    output in1_ready,
    output out_valid, out_data, out_sop, out_eop, out_channel,
    input  out_ready
  );

  modport master (
    output in0_valid, in0_data, in0_sop, in0_eop,
    input  in0_ready,
    output in1_valid, in1_data, in1_sop, in1_eop,
    input  in1_ready,
    input  out_valid, out_data, out_sop, out_eop, out_channel,
    output out_ready
  );
endinterface

// File: rtl/kernel_ddr3_mem_dmaster_st_arb.sv
// ---------------------------------------------------------------------------
// kernel_ddr3_mem_dmaster_st_arb
// Purpose : two-input packet arbiter for a byte stream. A grant is held for a
//           whole packet (sop..eop), so packets are never interleaved on the
//           output. Simultaneous requests are resolved round-robin. The output
//           is a single registered stage with 1-cycle latency.
// Ports   : clk          sole clock, rising edge
//           reset        synchronous, active-high
//           bus          stream interface (slave modport): in0_*, in1_*, out_*
//           busy         high while a packet grant is held
//           dbg_state_o  current FSM state (0 = IDLE, 1 = BUSY)
//           dbg_grant_o  index currently holding (or last given) the grant
// ---------------------------------------------------------------------------
module kernel_ddr3_mem_dmaster_st_arb #(
  parameter int DATA_W = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  kernel_ddr3_mem_dmaster_st_arb_if.slave bus,
  output logic                            busy,
  output logic                            dbg_state_o,
  output logic                            dbg_grant_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q;
  logic              grant_q;
  logic              last_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_sop_q;
  logic              out_eop_q;
  logic              out_channel_q;

  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              sel_sop;
  logic              sel_eop;
  logic              load;
  logic              accept;

  // Mux the granted requester onto a common set of wires.
  always_comb begin
    sel_valid = bus.in0_valid;
    sel_data  = bus.in0_data;
    sel_sop   = bus.in0_sop;
    sel_eop   = bus.in0_eop;
    if (grant_q) begin
      sel_valid = bus.in1_valid;
      sel_data  = bus.in1_data;
      sel_sop   = bus.in1_sop;
      sel_eop   = bus.in1_eop;
    end
  end

  // The output stage can take a beat when it is empty or being drained this
  // cycle; a stalled output therefore stalls the granted requester too.
  assign load   = (state_q == BUSY) && (!out_valid_q || bus.out_ready);
  assign accept = load && sel_valid;

  assign bus.in0_ready = load && !grant_q;
  assign bus.in1_ready = load &&  grant_q;

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_sop     = out_sop_q;
  assign bus.out_eop     = out_eop_q;
  assign bus.out_channel = out_channel_q;

  assign busy        = (state_q == BUSY);
  assign dbg_state_o = state_q;
  assign dbg_grant_o = grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      // last_q = 1 makes the first contested arbitration after reset go to in0.
      last_q        <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_channel_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Requests are just valid; sop is not inspected. Nothing is
          // accepted in this cycle, the grant takes effect next cycle.
          if (bus.in0_valid && bus.in1_valid) begin
            grant_q <= ~last_q;
            state_q <= BUSY;
          end else if (bus.in0_valid) begin
            grant_q <= 1'b0;
            state_q <= BUSY;
          end else if (bus.in1_valid) begin
            grant_q <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // Release on the accepted eop beat even though that beat still
          // sits in the output register; re-arbitration may overlap it.
          if (accept && sel_eop) begin
            state_q <= IDLE;
            last_q  <= grant_q;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        out_valid_q   <= 1'b1;
        out_data_q    <= sel_data;
        out_sop_q     <= sel_sop;
        out_eop_q     <= sel_eop;
        out_channel_q <= grant_q;
      end else if (bus.out_ready) begin
        // Beat drained with no replacement: payload fields keep their values.
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kernel_ddr3_mem_dmaster_st_arb.sv
module tb_kernel_ddr3_mem_dmaster_st_arb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic dbg_state;
  logic dbg_grant;

  always #5 clk = ~clk;

  kernel_ddr3_mem_dmaster_st_arb_if #(.DATA_W(8)) bus ();

  kernel_ddr3_mem_dmaster_st_arb #(.DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .dbg_state_o (dbg_state),
    .dbg_grant_o (dbg_grant)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // scoreboard entry: {channel, sop, eop, data}
  logic [10:0] exp_q[$];
  int          pop_cyc[$];
  logic [10:0] mon_got;
  logic [10:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time expired, expected finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d, input logic s, input logic e);
    exp_q.push_back({1'(ch), s, e, d});
  endtask

  // Monitor: a beat leaves the DUT on the next rising edge whenever
  // out_valid and out_ready are both high at the falling edge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      mon_got = {bus.out_channel, bus.out_sop, bus.out_eop, bus.out_data};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra_beat: got 0x%0h expected no beat", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_beat: got {ch,sop,eop,data}=0x%0h expected 0x%0h", mon_got, mon_exp);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int ch, input logic v, input logic [7:0] d, input logic s, input logic e);
    if (ch == 0) begin
      bus.in0_valid = v; bus.in0_data = d; bus.in0_sop = s; bus.in0_eop = e;
    end else begin
      bus.in1_valid = v; bus.in1_data = d; bus.in1_sop = s; bus.in1_eop = e;
    end
  endtask

  function automatic logic rdy(input int ch);
    return (ch == 0) ? bus.in0_ready : bus.in1_ready;
  endfunction

  // Present one beat and return once it has been accepted; lat counts the
  // rising edges from presentation up to and including the accepting edge.
  task automatic beat(input int ch, input logic [7:0] d, input logic s, input logic e,
                      output int lat);
    logic acc;
    lat = 0;
    drive(ch, 1'b1, d, s, e);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = rdy(ch);
      @(posedge clk);
      #1;
      lat++;
      if (acc) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL beat_timeout ch%0d: got no accept in 200 cycles, expected accept", ch);
  endtask

  // Send an n-beat packet; before beat gap_at valid drops for gap_len cycles.
  task automatic send(input int ch, input int n, input logic [7:0] base,
                      input int gap_at, input int gap_len, output int lat0);
    int lat;
    lat0 = 0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        drive(ch, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (gap_len) begin @(posedge clk); #1; end
      end
      beat(ch, base + 8'(i), (i == 0), (i == n - 1), lat);
      if (i == 0) lat0 = lat;
    end
    drive(ch, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) begin @(posedge clk); #1; end
    check({"drain_", name}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  int l0, l1, nv, r1;
  logic in0_done;

  initial begin
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    reset = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid",   bus.out_valid,   0);
    check("rst_out_data",    bus.out_data,    0);
    check("rst_out_sop",     bus.out_sop,     0);
    check("rst_out_eop",     bus.out_eop,     0);
    check("rst_out_channel", bus.out_channel, 0);
    check("rst_busy",        busy,            0);
    check("rst_in0_ready",   bus.in0_ready,   0);
    check("rst_in1_ready",   bus.in1_ready,   0);
    check("rst_state",       dbg_state,       0);
    check("rst_grant",       dbg_grant,       0);
    @(posedge clk); #1;
    reset = 1'b0;

    // both inputs request from reset: in0 packet first, one idle output cycle
    pop_cyc.delete();
    push(0, 8'h10, 1, 0); push(0, 8'h11, 0, 0); push(0, 8'h12, 0, 1);
    push(1, 8'h20, 1, 0); push(1, 8'h21, 0, 0); push(1, 8'h22, 0, 1);
    fork
      send(0, 3, 8'h10, -1, 0, l0);
      send(1, 3, 8'h20, -1, 0, l1);
    join
    drain("both3");
    check("both3_in0_first_latency", l0, 2);
    check("both3_beats", pop_cyc.size(), 6);
    if (pop_cyc.size() == 6) check("both3_idle_gap", pop_cyc[3] - pop_cyc[2], 2);

    // in0 streams packets while in1 is always valid: strict alternation
    for (int k = 0; k < 3; k++) begin
      push(0, 8'h40 + 8'(k * 16), 1, 0); push(0, 8'h41 + 8'(k * 16), 0, 1);
      push(1, 8'h80 + 8'(k * 16), 1, 0); push(1, 8'h81 + 8'(k * 16), 0, 1);
    end
    fork
      for (int k = 0; k < 3; k++) send(0, 2, 8'h40 + 8'(k * 16), -1, 0, l0);
      for (int k = 0; k < 3; k++) send(1, 2, 8'h80 + 8'(k * 16), -1, 0, l1);
    join
    drain("alternate");

    // in1 alone, single-beat packet
    push(1, 8'hA5, 1, 1);
    send(1, 1, 8'hA5, -1, 0, l1);
    check("single_grant_latency", l1, 2);
    nv = 0;
    repeat (6) begin @(negedge clk); if (bus.out_valid) nv++; end
    check("single_out_valid_cycles", nv, 1);
    drain("single");

    // backpressure: out_ready low for 4 cycles in the middle of an in0 packet
    push(0, 8'h30, 1, 0); push(0, 8'h31, 0, 0); push(0, 8'h32, 0, 1);
    fork
      send(0, 3, 8'h30, -1, 0, l0);
      begin
        nv = 0;
        for (int i = 0; i < 50 && nv == 0; i++) begin
          @(negedge clk);
          if (bus.out_valid) nv = 1;
        end
        check("stall_first_beat_seen", nv, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("stall_out_valid", bus.out_valid, 1);
          check("stall_out_data",  bus.out_data,  8'h31);
          check("stall_out_sop",   bus.out_sop,   0);
          check("stall_in0_ready", bus.in0_ready, 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("stall");

    // in0 pauses mid-packet; in1 must wait for in0's eop
    push(0, 8'hB0, 1, 0); push(0, 8'hB1, 0, 0); push(0, 8'hB2, 0, 0); push(0, 8'hB3, 0, 1);
    push(1, 8'hC0, 1, 0); push(1, 8'hC1, 0, 1);
    in0_done = 1'b0;
    r1 = 0;
    fork
      begin send(0, 4, 8'hB0, 2, 3, l0); in0_done = 1'b1; end
      begin @(posedge clk); #1; send(1, 2, 8'hC0, -1, 0, l1); end
      while (!in0_done) begin @(negedge clk); if (bus.in1_ready) r1++; end
    join
    check("hold_in1_ready_during_in0", r1, 0);
    check("hold_in1_wait_latency", l1, 9);
    drain("hold");

    // reset pulse while beat 2 of 4 sits in the output register
    push(0, 8'hD0, 1, 0);
    beat(0, 8'hD0, 1'b1, 1'b0, l0);
    beat(0, 8'hD1, 1'b0, 1'b0, l0);
    bus.out_ready = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_beat2_held", bus.out_data, 8'hD1);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy",      busy,          0);
    check("midrst_in0_ready", bus.in0_ready, 0);
    push(0, 8'hE0, 1, 1);
    push(1, 8'hF0, 1, 1);
    fork
      send(0, 1, 8'hE0, -1, 0, l0);
      send(1, 1, 8'hF0, -1, 0, l1);
    join
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
